// File: rtl/riscv_pkg.sv
// Shared RISC-V trace types: retire record layout, trace FSM states and the
// ebreak encoding that freezes capture.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h00100073;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      reg_addr;
      logic [XLEN-1:0] reg_data;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN-1:0] mem_data;
      logic            mem_wrt;
   } retire_rec_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FREEZE  = 2'd2
   } trace_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is read straight
// out of storage, so a written word becomes visible the cycle after the push.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures retired-instruction records into a FIFO between arm and stop/ebreak,
// counting accepted and dropped retires while readout continues in every state.
module retire_trace_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       arm_i,
   input  logic                       stop_i,
   input  logic                       ret_valid_i,
   input  logic [XLEN-1:0]            ret_pc_i,
   input  logic [XLEN-1:0]            ret_instr_i,
   input  logic [XLEN-1:0]            ret_reg_data_i,
   input  logic [XLEN-1:0]            ret_mem_addr_i,
   input  logic [XLEN-1:0]            ret_mem_data_i,
   input  logic [4:0]                 ret_reg_addr_i,
   input  logic                       ret_mem_wrt_i,
   output retire_rec_t                rec_o,
   output logic                       rec_valid_o,
   input  logic                       rec_ready_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [63:0]                retired_o,
   output logic [31:0]                dropped_o,
   output logic                       overflow_o,
   output trace_state_t               state_o
);

   localparam int RW = $bits(retire_rec_t);

   trace_state_t state;
   retire_rec_t  rec_in;
   logic [RW-1:0] fifo_rdata;
   logic fifo_full;
   logic fifo_empty;
   logic rec_pop;
   logic qualify;
   logic rec_push;
   logic rec_drop;
   logic is_ebreak;

   always_comb begin
      rec_in          = '0;
      rec_in.pc       = ret_pc_i;
      rec_in.instr    = ret_instr_i;
      rec_in.reg_addr = ret_reg_addr_i;
      rec_in.reg_data = ret_reg_data_i;
      rec_in.mem_addr = ret_mem_addr_i;
      rec_in.mem_data = ret_mem_data_i;
      rec_in.mem_wrt  = ret_mem_wrt_i;
   end

   assign rec_valid_o = !fifo_empty;
   assign rec_pop     = rec_valid_o && rec_ready_i;
   // Bubbles (all-zero instruction word) are never traced.
   assign qualify     = (state == ST_CAPTURE) && ret_valid_i && (ret_instr_i != '0);
   assign rec_push    = qualify && (!fifo_full || rec_pop);
   assign rec_drop    = qualify && !rec_push;
   assign is_ebreak   = (ret_instr_i == EBREAK_INSTR);
   assign rec_o       = retire_rec_t'(fifo_rdata);
   assign state_o     = state;

   sync_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (rec_push),
      .wdata (rec_in),
      .pop   (rec_pop),
      .rdata (fifo_rdata),
      .count (count_o),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         retired_o  <= '0;
         dropped_o  <= '0;
         overflow_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arm_i && !stop_i) state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // The ebreak retire itself is still pushed on this edge.
               if (stop_i || (qualify && is_ebreak)) state <= ST_FREEZE;
            end
            ST_FREEZE: begin
               if (fifo_empty && !arm_i) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase

         if (qualify) retired_o <= retired_o + 64'd1;

         if (state == ST_IDLE && arm_i && !stop_i) begin
            dropped_o  <= '0;
            overflow_o <= 1'b0;
         end else if (rec_drop) begin
            overflow_o <= 1'b1;
            if (dropped_o != '1) dropped_o <= dropped_o + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a queue-based model.
module tb_retire_trace_buffer;
   import riscv_pkg::*;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            arm_i = 1'b0;
   logic            stop_i = 1'b0;
   logic            ret_valid_i = 1'b0;
   logic [XLEN-1:0] ret_pc_i = '0;
   logic [XLEN-1:0] ret_instr_i = '0;
   logic [XLEN-1:0] ret_reg_data_i = '0;
   logic [XLEN-1:0] ret_mem_addr_i = '0;
   logic [XLEN-1:0] ret_mem_data_i = '0;
   logic [4:0]      ret_reg_addr_i = '0;
   logic            ret_mem_wrt_i = 1'b0;
   logic            rec_ready_i = 1'b0;
   retire_rec_t     rec_o;
   logic            rec_valid_o;
   logic [CW-1:0]   count_o;
   logic [63:0]     retired_o;
   logic [31:0]     dropped_o;
   logic            overflow_o;
   trace_state_t    state_o;

   // Reference model state
   retire_rec_t  m_q[$];
   trace_state_t m_state = ST_IDLE;
   logic [63:0]  m_retired = '0;
   logic [31:0]  m_dropped = '0;
   logic         m_ovf = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   retire_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .arm_i          (arm_i),
      .stop_i         (stop_i),
      .ret_valid_i    (ret_valid_i),
      .ret_pc_i       (ret_pc_i),
      .ret_instr_i    (ret_instr_i),
      .ret_reg_data_i (ret_reg_data_i),
      .ret_mem_addr_i (ret_mem_addr_i),
      .ret_mem_data_i (ret_mem_data_i),
      .ret_reg_addr_i (ret_reg_addr_i),
      .ret_mem_wrt_i  (ret_mem_wrt_i),
      .rec_o          (rec_o),
      .rec_valid_o    (rec_valid_o),
      .rec_ready_i    (rec_ready_i),
      .count_o        (count_o),
      .retired_o      (retired_o),
      .dropped_o      (dropped_o),
      .overflow_o     (overflow_o),
      .state_o        (state_o)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_rec(input string name, input retire_rec_t act, input retire_rec_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got pc=%h instr=%h rec=%h expected pc=%h instr=%h rec=%h at %0t",
                  name, act.pc, act.instr, act, exp.pc, exp.instr, exp, $time);
      end
   endtask

   // Model advance for one rising edge, using the inputs currently applied.
   task automatic model_step();
      retire_rec_t r;
      logic pop;
      logic qual;
      int   size_before;
      if (rst_i) begin
         m_q.delete();
         m_state   = ST_IDLE;
         m_retired = '0;
         m_dropped = '0;
         m_ovf     = 1'b0;
         return;
      end
      size_before = m_q.size();
      pop  = (size_before != 0) && rec_ready_i;
      qual = (m_state == ST_CAPTURE) && ret_valid_i && (ret_instr_i != 0);
      r.pc = ret_pc_i;  r.instr = ret_instr_i;  r.reg_addr = ret_reg_addr_i;
      r.reg_data = ret_reg_data_i;  r.mem_addr = ret_mem_addr_i;
      r.mem_data = ret_mem_data_i;  r.mem_wrt = ret_mem_wrt_i;
      if (pop) void'(m_q.pop_front());
      case (m_state)
         ST_IDLE:
            if (arm_i && !stop_i) begin
               m_state = ST_CAPTURE;  m_dropped = 0;  m_ovf = 1'b0;
            end
         ST_CAPTURE:
            if (stop_i || (qual && ret_instr_i == 32'h00100073)) m_state = ST_FREEZE;
         default:
            if (size_before == 0 && !arm_i) m_state = ST_IDLE;
      endcase
      if (qual) begin
         m_retired = m_retired + 1;
         if (size_before < DEPTH || pop) m_q.push_back(r);
         else begin
            m_ovf = 1'b1;
            if (m_dropped != 32'hFFFF_FFFF) m_dropped = m_dropped + 1;
         end
      end
   endtask

   task automatic compare_all();
      check("state", 64'(state_o), 64'(m_state));
      check("count", 64'(count_o), 64'(m_q.size()));
      check("rec_valid", 64'(rec_valid_o), 64'(m_q.size() != 0));
      check("retired", retired_o, m_retired);
      check("dropped", 64'(dropped_o), 64'(m_dropped));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
      if (m_q.size() != 0) check_rec("rec", rec_o, m_q[0]);
   endtask

   // One clock: model follows the edge, outputs are compared on the falling edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_retire(input logic valid, input logic [31:0] pc, input logic [31:0] instr);
      ret_valid_i    = valid;
      ret_pc_i       = pc;
      ret_instr_i    = instr;
      ret_reg_addr_i = 5'($urandom_range(0, 31));
      ret_reg_data_i = $urandom;
      ret_mem_addr_i = $urandom;
      ret_mem_data_i = $urandom;
      ret_mem_wrt_i  = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   logic [31:0] exp_pc[8];

   initial begin
      do_reset();
      check("reset_count", 64'(count_o), 64'd0);
      check("reset_state", 64'(state_o), 64'(ST_IDLE));
      check("reset_valid", 64'(rec_valid_o), 64'd0);

      // Three retires streamed out in order, one cycle after capture
      arm_i = 1'b1;  tick();  arm_i = 1'b0;
      rec_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_retire(1'b1, 32'(i * 4), 32'h0000_0013 + 32'(i << 7));
         tick();
         check("stream_valid", 64'(rec_valid_o), 64'd1);
         check("stream_pc", 64'(rec_o.pc), 64'(i * 4));
      end
      set_retire(1'b0, 32'h0, 32'h0);
      tick();
      check("stream_retired", retired_o, 64'd3);
      check("stream_empty", 64'(count_o), 64'd0);

      // Overflow: ten retires into an eight-entry FIFO with no reader
      do_reset();
      arm_i = 1'b1;  tick();  arm_i = 1'b0;
      rec_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_retire(1'b1, 32'h100 + 32'(i * 4), $urandom | 32'h1);
         if (ret_instr_i == EBREAK_INSTR) ret_instr_i = 32'h13;
         tick();
      end
      set_retire(1'b0, 32'h0, 32'h0);
      tick();
      check("ovf_count", 64'(count_o), 64'd8);
      check("ovf_dropped", 64'(dropped_o), 64'd2);
      check("ovf_flag", 64'(overflow_o), 64'd1);
      check("ovf_retired", retired_o, 64'd10);
      check("ovf_head_pc", 64'(rec_o.pc), 64'h100);

      // Full FIFO with push and pop on the same edge
      rec_ready_i = 1'b1;
      set_retire(1'b1, 32'h200, 32'h0000_0033);
      tick();
      check("fullpp_count", 64'(count_o), 64'd8);
      check("fullpp_dropped", 64'(dropped_o), 64'd2);
      check("fullpp_retired", retired_o, 64'd11);
      set_retire(1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 7; i++) exp_pc[i] = 32'h104 + 32'(i * 4);
      exp_pc[7] = 32'h200;
      for (int i = 0; i < 8; i++) begin
         check("drain_pc", 64'(rec_o.pc), 64'(exp_pc[i]));
         tick();
      end
      check("drain_empty", 64'(rec_valid_o), 64'd0);

      // ebreak captured and freezes; later retires ignored
      rec_ready_i = 1'b0;
      set_retire(1'b1, 32'h40, 32'h00100073);
      tick();
      check("ebreak_state", 64'(state_o), 64'(ST_FREEZE));
      check("ebreak_pc", 64'(rec_o.pc), 64'h40);
      check("ebreak_count", 64'(count_o), 64'd1);
      set_retire(1'b1, 32'h44, 32'h0000_0093);
      tick();  tick();
      check("freeze_ignored", 64'(count_o), 64'd1);
      check("freeze_retired", retired_o, 64'd12);
      set_retire(1'b0, 32'h0, 32'h0);
      rec_ready_i = 1'b1;
      tick();  tick();
      check("freeze_exit", 64'(state_o), 64'(ST_IDLE));

      // stop beats arm in IDLE; bubble retires ignored
      arm_i = 1'b1;  stop_i = 1'b1;  tick();
      check("stop_prio", 64'(state_o), 64'(ST_IDLE));
      stop_i = 1'b0;  tick();  arm_i = 1'b0;
      set_retire(1'b1, 32'h80, 32'h0);
      tick();
      check("bubble_count", 64'(count_o), 64'd0);
      check("bubble_retired", retired_o, 64'd12);

      // Reset mid-capture discards contents
      rec_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_retire(1'b1, 32'h300 + 32'(i * 4), 32'h13);
         tick();
      end
      set_retire(1'b0, 32'h0, 32'h0);
      check("pre_rst_count", 64'(count_o), 64'd5);
      do_reset();
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_valid", 64'(rec_valid_o), 64'd0);
      check("rst_state", 64'(state_o), 64'(ST_IDLE));
      check("rst_retired", retired_o, 64'd0);
      check("rst_dropped", 64'(dropped_o), 64'd0);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst_i       = ($urandom_range(0, 499) == 0);
         arm_i       = ($urandom_range(0, 9) == 0);
         stop_i      = ($urandom_range(0, 39) == 0);
         rec_ready_i = ($urandom_range(0, 3) != 0) && (c % 400 > 100);
         case ($urandom_range(0, 19))
            0:       set_retire(1'b1, $urandom, 32'h0);
            1:       set_retire(1'b1, $urandom, 32'h00100073);
            2, 3:    set_retire(1'b0, $urandom, $urandom);
            default: set_retire(1'b1, $urandom, $urandom | 32'h4);
         endcase
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port arm_i  input  1  request capture start.
REQ-005 SHALL have port stop_i  input  1  request capture stop.
REQ-006 SHALL have port ret_valid_i  input  1  core retire strobe, sampled at the rising edge.
REQ-007 SHALL have ports ret_pc_i, ret_instr_i, ret_reg_data_i, ret_mem_addr_i, ret_mem_data_i  input  XLEN each  retired PC, instruction, register data, memory address, memory data.
REQ-008 SHALL have ports ret_reg_addr_i  input  5  and ret_mem_wrt_i  input  1  retired destination register and memory write flag.
REQ-009 SHALL have port rec_o  output  retire_rec_t  head record.
REQ-010 SHALL have ports rec_valid_o  output  1  and rec_ready_i  input  1  drain handshake.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have ports retired_o  output  64  accepted-retire count, and dropped_o  output  32  overflow-drop count.
REQ-013 SHALL have ports overflow_o  output  1  sticky drop flag, and state_o  output  trace_state_t  FSM state.

Function
REQ-014 SHALL implement FSM IDLE, CAPTURE, FREEZE, encoded as trace_state_t.
REQ-015 SHALL move IDLE->CAPTURE when arm_i=1 and stop_i=0, clearing dropped_o and overflow_o on that edge.
REQ-016 SHALL move CAPTURE->FREEZE when stop_i=1, or when a qualifying retire has ret_instr_i=32'h00100073 (ebreak); the ebreak record itself SHALL be captured.
REQ-017 SHALL move FREEZE->IDLE only when the FIFO is empty and arm_i=0; stop_i SHALL take priority over arm_i in every state.
REQ-018 SHALL treat a retire as qualifying only when state is CAPTURE, ret_valid_i=1 and ret_instr_i!=0; bubbles SHALL be ignored.
REQ-019 SHALL increment retired_o by 1 for every qualifying retire, whether stored or dropped.
REQ-020 SHALL store a qualifying retire if the FIFO is not full, or if it is full and a pop happens on the same edge.
REQ-021 SHALL otherwise drop the record, increment dropped_o (saturating at 2^32-1) and set overflow_o.
REQ-022 SHALL pop when rec_valid_o=1 and rec_ready_i=1; rec_valid_o SHALL equal (count_o!=0).
REQ-023 SHALL present the stored record on rec_o one cycle after capture, with no push-to-output bypass, even when the FIFO was empty.
REQ-024 SHALL keep draining in all states, so capture stopping never blocks readout.
REQ-025 SHALL keep rec_o stable while rec_valid_o=1 and rec_ready_i=0.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count_o SHALL not change on a simultaneous push and pop.
REQ-027 SHALL let retired_o wrap modulo 2^64.

Reset
REQ-028 SHALL, on rst_i=1 at a rising edge, set state IDLE, pointers 0, count_o 0, rec_valid_o 0, retired_o 0, dropped_o 0, overflow_o 0.
REQ-029 SHALL give rst_i priority over all other inputs; a reset mid-capture discards FIFO contents, and FIFO storage itself needs no reset.

Structure
REQ-030 SHALL take retire_rec_t (packed: pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt), trace_state_t and the EBREAK encoding constant from riscv_pkg.
REQ-031 SHALL contain one sub-module, sync_fifo (parameterised width/depth, first-word-fall-through), with FSM and counters in the top.

Verification
REQ-032 SHALL cover: arm, 3 retires (pc 0x0,0x4,0x8), rec_ready_i=1 -> 3 records in order, each 1 cycle after capture; retired_o=3.
REQ-033 SHALL cover: DEPTH=8, rec_ready_i=0, 10 retires -> count_o=8, dropped_o=2, overflow_o=1, retired_o=10; drain yields pc of first 8 retires.
REQ-034 SHALL cover: full FIFO, push and pop on the same edge -> record stored, count_o stays 8, dropped_o unchanged.
REQ-035 SHALL cover: retire of instr 32'h00100073 at pc 0x40 -> record captured, state FREEZE next cycle, later retires ignored; drain and arm_i=0 -> IDLE.
REQ-036 SHALL cover: ret_valid_i=1 with instr 0 -> no push, retired_o unchanged; stop_i and arm_i both high in IDLE -> stays IDLE.
REQ-037 SHALL cover: rst_i=1 mid-capture with count_o=5 -> next cycle count_o=0, rec_valid_o=0, state IDLE, all counters 0.
